// File: rtl/stream_maxpool.sv
`default_nettype none
// ============================================================================
// Module   : stream_maxpool
// Brief    : Streaming signed max-pool over fixed-length vectors, one output
//            register, valid/ready on both sides. Define POOL_PARTIAL_EN to
//            also emit the max of a trailing partial window.
// Revision : 1.0 - initial release
// ============================================================================
module stream_maxpool #(
    parameter int T = 16,
    parameter int L = 13,
    parameter int P = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [T-1:0] s_data_in_y,
    input  logic         s_valid_y,
    output logic         s_ready_y,
    output logic [T-1:0] m_data_out_z,
    output logic         m_valid_z,
    input  logic         m_ready_z
);

    localparam int c_pos_w = (L > 1) ? $clog2(L) : 1;
    localparam int c_win_w = (P > 1) ? $clog2(P) : 1;
    localparam logic [c_pos_w-1:0] c_last_pos = c_pos_w'(L - 1);
    localparam logic [c_win_w-1:0] c_last_win = c_win_w'(P - 1);

    logic [c_pos_w-1:0] r_pos;
    logic [c_win_w-1:0] r_win;
    logic [T-1:0]       r_max;
    logic [T-1:0]       r_out_data;
    logic               r_out_valid;

    logic               w_ready;
    logic               w_accept;
    logic               w_last_pos;
    logic               w_win_close;
    logic               w_emit;
    logic [T-1:0]       w_new_max;

    assign w_ready     = !reset && (!r_out_valid || m_ready_z);
    assign w_accept    = s_valid_y && w_ready;
    assign w_last_pos  = (r_pos == c_last_pos);
    assign w_win_close = (r_win == c_last_win);

    // First sample of a window replaces the running max outright.
    assign w_new_max = ((r_win == '0) || ($signed(s_data_in_y) > $signed(r_max)))
                     ? s_data_in_y : r_max;

`ifdef POOL_PARTIAL_EN
    assign w_emit = w_win_close || w_last_pos;
`else
    assign w_emit = w_win_close;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pos       <= '0;
            r_win       <= '0;
            r_max       <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_max <= w_new_max;
                r_pos <= w_last_pos ? '0 : r_pos + c_pos_w'(1);
                r_win <= (w_last_pos || w_win_close) ? '0 : r_win + c_win_w'(1);
            end
            if (w_accept && w_emit) begin
                r_out_data  <= w_new_max;
                r_out_valid <= 1'b1;
            end else if (r_out_valid && m_ready_z) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign s_ready_y    = w_ready;
    assign m_data_out_z = r_out_data;
    assign m_valid_z    = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_stream_maxpool.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_maxpool
// Brief    : Randomised and directed bench for stream_maxpool against a
//            queue-based window model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stream_maxpool;

    localparam int T = 16;
    localparam int L = 13;
    localparam int P = 2;
`ifdef POOL_PARTIAL_EN
    localparam int c_per = 7;
`else
    localparam int c_per = 6;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [T-1:0]  s_data_in_y = '0;
    logic          s_valid_y = 1'b0;
    logic          s_ready_y;
    logic [T-1:0]  m_data_out_z;
    logic          m_valid_z;
    logic          m_ready_z = 1'b0;

    int n_vec = 0;
    int n_err = 0;
    int n_acc = 0;

    logic [15:0]        stim[$];
    logic [15:0]        exp_q[$];
    logic [15:0]        got[$];
    logic signed [15:0] win_q[$];
    int                 mpos = 0;

    int          gap_mode = 0;
    int          rdy_mode = 0;
    bit          chk_rdy1 = 0;
    bit          exp_valid_next = 0;
    bit          held = 0;
    logic [15:0] held_data = '0;

    stream_maxpool #(.T(T), .L(L), .P(P)) dut (
        .clk          (clk),
        .reset        (reset),
        .s_data_in_y  (s_data_in_y),
        .s_valid_y    (s_valid_y),
        .s_ready_y    (s_ready_y),
        .m_data_out_z (m_data_out_z),
        .m_valid_z    (m_valid_z),
        .m_ready_z    (m_ready_z)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [15:0] win_max();
        logic signed [15:0] m;
        m = win_q[0];
        foreach (win_q[i]) if (win_q[i] > m) m = win_q[i];
        return m;
    endfunction

    // Reference: group accepted samples into windows of P, restart at each vector end.
    task automatic model_accept(input logic [15:0] s, output bit closed);
        closed = 0;
        win_q.push_back($signed(s));
        if (win_q.size() == P) begin
            exp_q.push_back(win_max());
            win_q.delete();
            closed = 1;
        end
        mpos++;
        if (mpos == L) begin
`ifdef POOL_PARTIAL_EN
            if (win_q.size() > 0) begin
                exp_q.push_back(win_max());
                closed = 1;
            end
`endif
            win_q.delete();
            mpos = 0;
        end
    endtask

    task automatic cycle();
        bit closed;
        @(negedge clk);
        if (stim.size() > 0 && (gap_mode == 0 || $urandom_range(0, 2) != 0)) begin
            s_valid_y   = 1'b1;
            s_data_in_y = stim[0];
        end else begin
            s_valid_y   = 1'b0;
            s_data_in_y = 16'($urandom);
        end
        case (rdy_mode)
            0:       m_ready_z = 1'b1;
            1:       m_ready_z = 1'($urandom_range(0, 1));
            default: m_ready_z = 1'b0;
        endcase
        #1;
        if (exp_valid_next) chk("latency", 32'(m_valid_z), 1);
        if (held) begin
            chk("hold_valid", 32'(m_valid_z), 1);
            chk("hold_data", 32'(m_data_out_z), 32'(held_data));
        end
        chk("ready_rule", 32'(s_ready_y), 32'(!m_valid_z || m_ready_z));
        if (chk_rdy1) chk("ready_one", 32'(s_ready_y), 1);
        if (m_valid_z && m_ready_z) begin
            if (exp_q.size() == 0) chk("spurious_z", 32'(m_data_out_z), 32'hFFFF_FFFF);
            else chk("zdata", 32'(m_data_out_z), 32'(exp_q.pop_front()));
            got.push_back(m_data_out_z);
        end
        held      = m_valid_z && !m_ready_z;
        held_data = m_data_out_z;
        exp_valid_next = 0;
        if (s_valid_y && s_ready_y) begin
            model_accept(stim.pop_front(), closed);
            exp_valid_next = closed;
            n_acc++;
        end
    endtask

    task automatic run(input int budget);
        int k = 0;
        while ((stim.size() > 0 || exp_q.size() > 0 || m_valid_z) && k < budget) begin
            cycle();
            k++;
        end
        if (k >= budget) chk("timeout", 0, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; s_valid_y = 1'b0; m_ready_z = 1'b0;
        #1;
        chk("rst_ready", 32'(s_ready_y), 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_valid", 32'(m_valid_z), 0);
        chk("rst_data", 32'(m_data_out_z), 0);
        stim.delete(); exp_q.delete(); win_q.delete();
        mpos = 0; held = 0; exp_valid_next = 0;
    endtask

    task automatic push_ramp(input int base);
        for (int i = 1; i <= L; i++) stim.push_back(16'(base + i));
    endtask

    // Ramp base+1..base+13 pools to base+2,4,..,12 (plus base+13 with partials).
    task automatic check_ramp(input string tag, input int base, input int first);
        for (int k = 0; k < c_per; k++) begin
            if (first + k < got.size())
                chk(tag, 32'(got[first + k]), (k < 6) ? 32'(base + 2 * (k + 1)) : 32'(base + 13));
        end
    endtask

    initial begin
        logic [15:0] sgn [13];
        logic [15:0] ext [4];
        sgn = '{16'hFFFB, 16'hFFFD, 16'h8000, 16'h7FFF, 16'h0007, 16'h0007,
                16'hFFFF, 16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005};
        ext = '{16'h8000, 16'h7FFF, 16'h0000, 16'hFFFF};

        @(negedge clk); @(negedge clk); #1;
        chk("init_ready", 32'(s_ready_y), 0);
        chk("init_valid", 32'(m_valid_z), 0);
        chk("init_data", 32'(m_data_out_z), 0);
        reset = 1'b0;

        // Plain ramp, no stalls
        got.delete(); chk_rdy1 = 1; push_ramp(0); run(200); chk_rdy1 = 0;
        chk("ramp_count", 32'(got.size()), c_per);
        check_ramp("ramp_z", 0, 0);

        // Signed extremes
        got.delete();
        foreach (sgn[i]) stim.push_back(sgn[i]);
        run(200);
        chk("sgn_count", 32'(got.size()), c_per);
        if (got.size() >= 4) begin
            chk("sgn_z0", 32'(got[0]), 32'h0000_FFFD);
            chk("sgn_z1", 32'(got[1]), 32'h0000_7FFF);
            chk("sgn_z2", 32'(got[2]), 32'h0000_0007);
            chk("sgn_z3", 32'(got[3]), 32'h0000_0000);
        end

        // Downstream stall right after the first window closes
        got.delete(); rdy_mode = 2; push_ramp(0);
        for (int i = 0; i < 6; i++) cycle();
        chk("stall_valid", 32'(m_valid_z), 1);
        chk("stall_data", 32'(m_data_out_z), 2);
        chk("stall_ready", 32'(s_ready_y), 0);
        chk("stall_left", 32'(stim.size()), 11);
        rdy_mode = 0; run(200);
        chk("stall_count", 32'(got.size()), c_per);
        check_ramp("stall_z", 0, 0);

        // Back-to-back vectors realign windows at the boundary
        got.delete(); push_ramp(0); push_ramp(100); run(300);
        chk("b2b_count", 32'(got.size()), 2 * c_per);
        if (got.size() > c_per) chk("b2b_realign", 32'(got[c_per]), 102);
        check_ramp("b2b_z", 100, c_per);

        // Reset after five accepted samples
        push_ramp(0); n_acc = 0;
        for (int i = 0; i < 50 && n_acc < 5; i++) cycle();
        chk("pre_rst_acc", 32'(n_acc), 5);
        do_reset();
        got.delete(); push_ramp(0); run(200);
        chk("post_rst_count", 32'(got.size()), c_per);
        check_ramp("post_rst_z", 0, 0);

        // Random gaps on both sides, ramp then random data
        gap_mode = 1; rdy_mode = 1;
        got.delete(); push_ramp(0); run(1000);
        chk("gap_count", 32'(got.size()), c_per);
        check_ramp("gap_z", 0, 0);
        got.delete();
        for (int v = 0; v < 8; v++)
            for (int i = 0; i < L; i++)
                stim.push_back(($urandom_range(0, 3) == 0) ? ext[$urandom_range(0, 3)] : 16'($urandom));
        run(5000);
        chk("rand_count", 32'(got.size()), 8 * c_per);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
